aes_decrypt: RTL
================

AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL provide parameter DONE_PULSE, default 1, meaning 1 = done is a one-enabled-cycle pulse, 0 = done held high until next accepted start.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port en  input  1  clock enable; all state frozen when low.
REQ-005 SHALL provide port start  input  1  request decryption of din under key.
REQ-006 SHALL provide port din  input  128  ciphertext block, byte 0 at [127:120], column-major state order.
REQ-007 SHALL provide port key  input  128  AES-128 cipher key, same byte order.
REQ-008 SHALL provide port dout  output  128  plaintext result register.
REQ-009 SHALL provide port busy  output  1  high from accept until completion.
REQ-010 SHALL provide port done  output  1  completion indication per DONE_PULSE.

Function
REQ-011 SHALL implement FIPS-197 AES-128 inverse cipher, inverting the team's iterative encryptor bit-exactly.
REQ-012 SHALL accept start only when en=1, busy=0 and rst=0; din and key are latched on the accept edge; start while busy is ignored.
REQ-013 SHALL use FSM states IDLE, KEYEXP, ADDK, ROUND, FINAL; transitions only on edges with en=1.
REQ-014 SHALL go IDLE->KEYEXP on accept; rk0 = latched key.
REQ-015 SHALL, in KEYEXP, compute one forward round key per cycle (rk1..rk10, Rcon 01,02,04,08,10,20,40,80,1b,36) into a 10-entry key store, then go to ADDK.
REQ-016 SHALL, in ADDK, load state = state ^ rk10 (1 cycle), then go to ROUND with round counter = 9.
REQ-017 SHALL, in ROUND, load state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]) and decrement r; after r=1, go to FINAL.
REQ-018 SHALL, in FINAL, load dout = InvSubBytes(InvShiftRows(state)) ^ rk0, clear busy, assert done, and return to IDLE.
REQ-019 SHALL complete in 21 enabled cycles after the accept edge (10 KEYEXP + 1 ADDK + 9 ROUND + 1 FINAL); dout/done valid after the 21st.
REQ-020 SHALL keep dout unchanged except at FINAL; dout holds the last result indefinitely.
REQ-021 SHALL, with DONE_PULSE=1, drop done on the next enabled edge; with DONE_PULSE=0, hold done until the next accept edge.
REQ-022 SHALL, when en=0, hold the FSM, counter, key store, dout, busy and done unchanged; done stays high across disabled cycles.
REQ-023 SHALL allow start in the same cycle done is high (back-to-back); the new job is accepted and done falls on that edge.

Reset
REQ-024 SHALL, on rst=1 at a clock edge regardless of en, set FSM=IDLE, busy=0, done=0, dout=0, round counter=0.
REQ-025 SHALL abort an in-flight operation on reset mid-operation, with no partial result written to dout.
REQ-026 SHALL give rst priority over start in the same cycle.
REQ-027 SHALL leave key store contents undefined after reset; they are never observed before being rewritten, or before the cache is revalidated per REQ-029.

Configuration
REQ-028 SHALL support macro AES_DECRYPT_KEYCACHE_EN.
REQ-029 SHALL, when AES_DECRYPT_KEYCACHE_EN is defined, keep a cached-key register plus a valid flag (cleared by reset, set at the end of KEYEXP); on accept with valid=1 and key equal to the cached key, skip KEYEXP and go directly to ADDK, giving 11-cycle latency.
REQ-030 SHALL, when AES_DECRYPT_KEYCACHE_EN is undefined, always run KEYEXP (21-cycle latency) and contain no cache register or comparator.

Verification
REQ-031 Bench SHALL cover: key 000102030405060708090a0b0c0d0e0f, din 69c4e0d86a7b0430d8cdb78070b4c55a, en=1 -> dout 00112233445566778899aabbccddeeff, done 21 cycles after accept.
REQ-032 Bench SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, din 3925841d02dc09fbdc118597196a0b32, en toggled 50% -> dout 3243f6a8885a308d313198a2e0370734 after 21 enabled cycles, done held across low-en cycles.
REQ-033 Bench SHALL cover: start at cycle 5 of a job -> ignored, first result unchanged, busy stays high.
REQ-034 Bench SHALL cover: rst at ROUND r=4 -> next cycle busy=0, done=0, dout=0; fresh start then yields the correct result.
REQ-035 Bench SHALL cover: with AES_DECRYPT_KEYCACHE_EN, a second job with the same key -> done 11 cycles after accept; with a different key -> 21 cycles.
REQ-036 Bench SHALL cover: back-to-back start on the done cycle under DONE_PULSE=0 -> done falls, busy rises, second result correct.

Source files
------------

// File: rtl/aes_decrypt_if.sv
// aes_decrypt_if -- handshake and data bundle for the AES-128 block decryptor.
//
// Signals:
//   en     clock enable; all decryptor state frozen while low
//   start  request decryption of din under key
//   din    128-bit ciphertext, byte 0 at [127:120], column-major state order
//   key    128-bit AES-128 cipher key, same byte order
//   dout   128-bit plaintext result register
//   busy   high from accept until completion
//   done   completion indication (pulse or level, see DONE_PULSE on aes_decrypt)
//
// Modports: master drives requests (testbench / host), slave is the decryptor.
interface aes_decrypt_if;
   logic         en;
   logic         start;
   logic [127:0] din;
   logic [127:0] key;
   logic [127:0] dout;
   logic         busy;
   logic         done;

   modport master (
      output en, start, din, key,
      input  dout, busy, done
   );

   modport slave (
      input  en, start, din, key,
      output dout, busy, done
   );
endinterface

// File: rtl/aes_decrypt.sv
// aes_decrypt -- iterative FIPS-197 AES-128 inverse cipher.
//
// Ports:
//   clk  sole clock, all state updates on the rising edge
//   rst  synchronous active-high reset (wins over en and start)
//   bus  aes_decrypt_if.slave: en, start, din, key in; dout, busy, done out
//
// Parameter DONE_PULSE: 1 = done is a one-enabled-cycle pulse,
//                       0 = done held high until the next accepted start.
//
// Sequence per job: KEYEXP (10 cycles, forward round keys rk1..rk10), ADDK (1),
// ROUND (9, r = 9..1), FINAL (1) -> 21 enabled cycles after the accept edge.
//
// Optional macro AES_DECRYPT_KEYCACHE_EN: remembers the last fully expanded key;
// a job whose key matches it skips KEYEXP (11-cycle latency).
module aes_decrypt #(
   parameter int unsigned DONE_PULSE = 1
) (
   input logic        clk,
   input logic        rst,
   aes_decrypt_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StKeyexp, StAddk, StRound, StFinal} state_e;

   state_e       fsm_q;
   logic [3:0]   cnt_q;
   logic [127:0] key_q;
   logic [127:0] blk_q;
   logic [127:0] rk_q [1:10];
   logic [127:0] dout_q;
   logic         busy_q;
   logic         done_q;

   logic [127:0] prev_rk;
   logic [127:0] rk_next;
   logic         hit;

   // GF(2^8) arithmetic, AES polynomial x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a12  = gmul(gmul(a3, a3), gmul(a3, a3));
      a15  = gmul(a12, a3);
      a240 = gmul(a15, a15);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   // InvShiftRows followed by InvSubBytes; byte b sits at row b%4, column b/4.
   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32 * c -: 8];
         a1 = s[119 - 32 * c -: 8];
         a2 = s[111 - 32 * c -: 8];
         a3 = s[103 - 32 * c -: 8];
         o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Forward key schedule step: rk[i] from rk[i-1].
   function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sbox(p[23:16]) ^ rc, sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])};
      n0 = p[127:96] ^ t;
      n1 = p[95:64] ^ n0;
      n2 = p[63:32] ^ n1;
      n3 = p[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   always_comb begin
      prev_rk = (cnt_q == 4'd1) ? key_q : rk_q[cnt_q - 4'd1];
      rk_next = key_step(prev_rk, rcon(cnt_q));
   end

`ifdef AES_DECRYPT_KEYCACHE_EN
   logic [127:0] cache_key_q;
   logic         cache_vld_q;
   assign hit = cache_vld_q && (bus.key == cache_key_q);
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= StIdle;
         cnt_q  <= 4'd0;
         dout_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef AES_DECRYPT_KEYCACHE_EN
         cache_vld_q <= 1'b0;
`endif
      end else if (bus.en) begin
         if (DONE_PULSE != 0) done_q <= 1'b0;
         unique case (fsm_q)
            StIdle: begin
               if (bus.start) begin
                  key_q  <= bus.key;
                  blk_q  <= bus.din;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  if (hit) begin
                     fsm_q <= StAddk;
                  end else begin
                     fsm_q <= StKeyexp;
                     cnt_q <= 4'd1;
`ifdef AES_DECRYPT_KEYCACHE_EN
                     // Key store is about to be overwritten.
                     cache_vld_q <= 1'b0;
`endif
                  end
               end
            end
            StKeyexp: begin
               rk_q[cnt_q] <= rk_next;
               cnt_q       <= cnt_q + 4'd1;
               if (cnt_q == 4'd10) begin
                  fsm_q <= StAddk;
`ifdef AES_DECRYPT_KEYCACHE_EN
                  cache_key_q <= key_q;
                  cache_vld_q <= 1'b1;
`endif
               end
            end
            StAddk: begin
               blk_q <= blk_q ^ rk_q[10];
               cnt_q <= 4'd9;
               fsm_q <= StRound;
            end
            StRound: begin
               blk_q <= inv_mix(inv_sr_sb(blk_q) ^ rk_q[cnt_q]);
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) fsm_q <= StFinal;
            end
            StFinal: begin
               dout_q <= inv_sr_sb(blk_q) ^ key_q;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               fsm_q  <= StIdle;
            end
            default: fsm_q <= StIdle;
         endcase
      end
   end

   assign bus.dout = dout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
